argmax_stream: RTL and testbench

- Parametrised streaming arg-max classifier for the CNN output stage.
- Receives one score vector of NUM_CLASS scores from the final dense layer, LANES scores per beat, over a valid/ready handshake.
- Returns the index of the largest score and the score itself over a second valid/ready handshake.
- Generalises the fixed 4-input max/index block: configurable width, class count and lane count, signed compare, tie rule, and backpressure.

---
 rtl/cnn_pkg.sv | 37 +++
 rtl/argmax_lane_reduce.sv | 52 +++++
 rtl/argmax_stream.sv | 139 +++++++++++++
 tb/tb_argmax_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN output-stage blocks.
// Holds the arg-max FSM encoding, a clog2 helper and the score comparator.
package cnn_pkg;

  localparam int unsigned SCORE_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnn_clog2(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Scores arrive zero-extended; flipping bit w-1 maps two's complement onto
  // offset binary so a single unsigned compare serves both modes.
  function automatic logic score_gt(input logic [SCORE_MAX_W-1:0] a,
                                    input logic [SCORE_MAX_W-1:0] b,
                                    input int unsigned            w,
                                    input logic                   signed_cmp);
    logic [SCORE_MAX_W-1:0] msb_mask;
    msb_mask = signed_cmp ? (64'd1 << (w - 32'd1)) : 64'd0;
    return (a ^ msb_mask) > (b ^ msb_mask);
  endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// Combinational max tree over the lanes of one input beat.
// Returns the winning score and its lane; the lower lane wins a tie.
module argmax_lane_reduce
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LANES      = 2,
  parameter int unsigned SIGNED_CMP = 1,
  parameter int unsigned LIDX_W     = (LANES > 1) ? cnn_clog2(LANES) : 1
) (
  input  logic [LANES*DATA_W-1:0] lane_data,
  output logic [DATA_W-1:0]       win_score,
  output logic [LIDX_W-1:0]       win_lane
);

  localparam int unsigned PAD   = 32'd1 << cnn_clog2(LANES);
  localparam int unsigned NODES = 2 * PAD - 1;

  logic [DATA_W-1:0] node_score_s [NODES];
  logic [LIDX_W-1:0] node_lane_s  [NODES];
  logic              node_vld_s   [NODES];

  // Heap-ordered tree: leaves at PAD-1.., padding leaves never win.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      node_score_s[n] = '0;
      node_lane_s[n]  = '0;
      node_vld_s[n]   = 1'b0;
    end
    for (int k = 0; k < LANES; k++) begin
      node_score_s[PAD-1+k] = lane_data[k*DATA_W +: DATA_W];
      node_lane_s[PAD-1+k]  = LIDX_W'(k);
      node_vld_s[PAD-1+k]   = 1'b1;
    end
    for (int n = int'(PAD) - 2; n >= 0; n--) begin
      if (node_vld_s[2*n+2] &&
          (!node_vld_s[2*n+1] ||
           score_gt(SCORE_MAX_W'(node_score_s[2*n+2]), SCORE_MAX_W'(node_score_s[2*n+1]),
                    DATA_W, SIGNED_CMP != 32'd0))) begin
        node_score_s[n] = node_score_s[2*n+2];
        node_lane_s[n]  = node_lane_s[2*n+2];
      end else begin
        node_score_s[n] = node_score_s[2*n+1];
        node_lane_s[n]  = node_lane_s[2*n+1];
      end
      node_vld_s[n] = node_vld_s[2*n+1] | node_vld_s[2*n+2];
    end
    win_score = node_score_s[0];
    win_lane  = node_lane_s[0];
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming arg-max classifier: accepts a score vector LANES scores per beat
// and returns the index and value of the largest score over valid/ready.
module argmax_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_CLASS  = 10,
  parameter int unsigned LANES      = 2,
  parameter int unsigned SIGNED_CMP = 1,
  parameter int unsigned IDX_W      = cnn_clog2(NUM_CLASS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [IDX_W-1:0]        o_class,
  output logic [DATA_W-1:0]       o_max,
  output logic                    o_busy
);

  localparam int unsigned BEATS  = NUM_CLASS / LANES;
  localparam int unsigned BCNT_W = (BEATS > 1) ? cnn_clog2(BEATS) : 1;
  localparam int unsigned LIDX_W = (LANES > 1) ? cnn_clog2(LANES) : 1;

  state_t              state_r, state_nxt_s;
  logic [BCNT_W-1:0]   beat_cnt_r, beat_cnt_nxt_s;
  logic [DATA_W-1:0]   run_max_r, run_max_nxt_s;
  logic [IDX_W-1:0]    run_idx_r, run_idx_nxt_s;
  logic                o_valid_r, o_busy_r, o_ready_r;

  logic [DATA_W-1:0]   lane_score_s;
  logic [LIDX_W-1:0]   lane_idx_s;
  logic [IDX_W-1:0]    cand_idx_s;
  logic                cand_gt_s;
  logic                in_xfer_s, out_xfer_s, last_beat_s;

  argmax_lane_reduce #(
    .DATA_W     (DATA_W),
    .LANES      (LANES),
    .SIGNED_CMP (SIGNED_CMP),
    .LIDX_W     (LIDX_W)
  ) u_lane_reduce (
    .lane_data (i_data),
    .win_score (lane_score_s),
    .win_lane  (lane_idx_s)
  );

  assign in_xfer_s   = i_valid && o_ready_r;
  assign out_xfer_s  = o_valid_r && i_ready;
  assign last_beat_s = (beat_cnt_r == BCNT_W'(BEATS - 1));
  assign cand_idx_s  = IDX_W'(32'(beat_cnt_r) * LANES + 32'(lane_idx_s));
  assign cand_gt_s   = score_gt(SCORE_MAX_W'(lane_score_s), SCORE_MAX_W'(run_max_r),
                                DATA_W, SIGNED_CMP != 32'd0);

  // Next-state and running max; strict compare lets earlier beats keep ties.
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    run_max_nxt_s  = run_max_r;
    run_idx_nxt_s  = run_idx_r;
    case (state_r)
      IDLE: begin
        if (in_xfer_s) begin
          run_max_nxt_s = lane_score_s;
          run_idx_nxt_s = cand_idx_s;
          if (BEATS == 1) begin
            state_nxt_s    = DONE;
            beat_cnt_nxt_s = '0;
          end else begin
            state_nxt_s    = ACC;
            beat_cnt_nxt_s = BCNT_W'(1);
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (in_xfer_s) begin
          if (cand_gt_s) begin
            run_max_nxt_s = lane_score_s;
            run_idx_nxt_s = cand_idx_s;
          end else begin
            run_max_nxt_s = run_max_r;
          end
          if (last_beat_s) begin
            state_nxt_s    = DONE;
            beat_cnt_nxt_s = '0;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + BCNT_W'(1);
          end
        end else begin
          state_nxt_s = ACC;
        end
      end
      DONE: begin
        if (out_xfer_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        beat_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, running registers and handshake flags, decoded from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      beat_cnt_r <= '0;
      run_max_r  <= '0;
      run_idx_r  <= '0;
      o_valid_r  <= 1'b0;
      o_busy_r   <= 1'b0;
      o_ready_r  <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      run_max_r  <= run_max_nxt_s;
      run_idx_r  <= run_idx_nxt_s;
      o_valid_r  <= (state_nxt_s == DONE);
      o_busy_r   <= (state_nxt_s == ACC);
      o_ready_r  <= (state_nxt_s != DONE);
    end
  end

  assign o_valid = o_valid_r;
  assign o_busy  = o_busy_r;
  assign o_ready = o_ready_r;
  assign o_class = run_idx_r;
  assign o_max   = run_max_r;

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: signed, unsigned and single-lane instances checked
// against a whole-vector arg-max reference with directed and random vectors.
module tb_argmax_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready;
  logic [31:0] i_data;
  logic        o_ready, o_valid, o_busy;
  logic [3:0]  o_class;
  logic [15:0] o_max;
  logic        u_o_ready, u_o_valid, u_o_busy;
  logic [3:0]  u_o_class;
  logic [15:0] u_o_max;
  logic        l_i_valid, l_i_ready;
  logic [15:0] l_i_data;
  logic        l_o_ready, l_o_valid, l_o_busy;
  logic [1:0]  l_o_class;
  logic [15:0] l_o_max;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] vec  [10];
  logic [15:0] lvec [10];
  logic [15:0] pool [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  always #5 clk = ~clk;

  argmax_stream #(.SIGNED_CMP(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_class(o_class), .o_max(o_max), .o_busy(o_busy));

  argmax_stream #(.SIGNED_CMP(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(u_o_ready), .i_data(i_data),
    .o_valid(u_o_valid), .i_ready(i_ready), .o_class(u_o_class), .o_max(u_o_max),
    .o_busy(u_o_busy));

  argmax_stream #(.LANES(1), .NUM_CLASS(4)) dut_l (
    .clk(clk), .rst_n(rst_n), .i_valid(l_i_valid), .o_ready(l_o_ready), .i_data(l_i_data),
    .o_valid(l_o_valid), .i_ready(l_i_ready), .o_class(l_o_class), .o_max(l_o_max),
    .o_busy(l_o_busy));

  // Reference: scan every class, keep the first strictly greater score.
  function automatic int ref_argmax(input logic [15:0] v [10], input int n, input bit sgn);
    int best;
    best = 0;
    for (int c = 1; c < n; c++) begin
      if (sgn ? ($signed(v[c]) > $signed(v[best])) : (v[c] > v[best])) best = c;
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_vec(input int nbeats, input int gap_at, input int gap_len);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      chk("ready_for_beat", 32'(o_ready), 32'd1);
      i_valid = 1'b1;
      i_data  = {vec[2*b+1], vec[2*b]};
      @(posedge clk);
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          i_valid = 1'b0;
          i_data  = $urandom;
          chk("busy_in_gap", 32'(o_busy), 32'd1);
        end
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    int si, ui;
    si = ref_argmax(vec, 10, 1'b1);
    ui = ref_argmax(vec, 10, 1'b0);
    chk({tag, "_valid"},   32'(o_valid),   32'd1);
    chk({tag, "_class"},   32'(o_class),   32'(si));
    chk({tag, "_max"},     32'(o_max),     32'(vec[si]));
    chk({tag, "_ready"},   32'(o_ready),   32'd0);
    chk({tag, "_busy"},    32'(o_busy),    32'd0);
    chk({tag, "_u_valid"}, 32'(u_o_valid), 32'd1);
    chk({tag, "_u_class"}, 32'(u_o_class), 32'(ui));
    chk({tag, "_u_max"},   32'(u_o_max),   32'(vec[ui]));
  endtask

  task automatic drain(input int hold, input string tag);
    int si;
    si = ref_argmax(vec, 10, 1'b1);
    if (hold > 0) i_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1;
      i_data  = {16'h7FFF, 16'h7FFF};
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_hold_class"}, 32'(o_class), 32'(si));
      chk({tag, "_hold_max"},   32'(o_max),   32'(vec[si]));
      chk({tag, "_hold_ready"}, 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_drop_valid"}, 32'(o_valid),   32'd0);
    chk({tag, "_drop_ready"}, 32'(o_ready),   32'd1);
    chk({tag, "_drop_u"},     32'(u_o_valid), 32'd0);
  endtask

  task automatic l_run(input string tag);
    int li;
    li = ref_argmax(lvec, 4, 1'b1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk({tag, "_early_valid"}, 32'(l_o_valid), 32'd0);
      chk({tag, "_ready"},       32'(l_o_ready), 32'd1);
      l_i_valid = 1'b1;
      l_i_data  = lvec[b];
      @(posedge clk);
    end
    @(negedge clk);
    l_i_valid = 1'b0;
    chk({tag, "_valid"},   32'(l_o_valid), 32'd1);
    chk({tag, "_class"},   32'(l_o_class), 32'(li));
    chk({tag, "_max"},     32'(l_o_max),   32'(lvec[li]));
    chk({tag, "_nready"},  32'(l_o_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_drop"},    32'(l_o_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_data    = 32'd0;
    l_i_valid = 1'b0;
    l_i_ready = 1'b1;
    l_i_data  = 16'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid),   32'd0);
    chk("rst_busy",  32'(o_busy),    32'd0);
    chk("rst_ready", 32'(o_ready),   32'd1);
    chk("rst_class", 32'(o_class),   32'd0);
    chk("rst_max",   32'(o_max),     32'd0);
    chk("rst_l",     32'(l_o_valid), 32'd0);
    rst_n = 1'b1;

    // Back-to-back reference vector; tie between classes 3 and 7.
    vec = '{16'd3, 16'd7, 16'd2, 16'd9, 16'd1, 16'd0, 16'd5, 16'd9, 16'd4, 16'd8};
    send_vec(5, -1, 0);
    check_result("b2b");
    chk("b2b_lit_class", 32'(o_class), 32'd3);
    chk("b2b_lit_max",   32'(o_max),   32'd9);
    drain(0, "b2b");

    for (int c = 0; c < 10; c++) vec[c] = 16'hFFF0;
    vec[6] = 16'hFFFE;
    send_vec(5, -1, 0);
    check_result("neg");
    chk("neg_lit_s", 32'(o_class),   32'd6);
    chk("neg_lit_u", 32'(u_o_class), 32'd6);
    drain(0, "neg");
    vec[2] = 16'h0001;
    send_vec(5, -1, 0);
    check_result("mix");
    chk("mix_lit_s", 32'(o_class),   32'd2);
    chk("mix_lit_u", 32'(u_o_class), 32'd6);
    drain(4, "bp");

    // Bubbles between beats 2 and 3.
    vec = '{16'd3, 16'd7, 16'd2, 16'd9, 16'd1, 16'd0, 16'd5, 16'd9, 16'd4, 16'd8};
    send_vec(5, 1, 1);
    check_result("gap1");
    drain(0, "gap1");
    send_vec(5, 1, 3);
    check_result("gap3");
    drain(0, "gap3");

    // Reset mid-vector, then a vector whose max is class 0.
    for (int c = 0; c < 10; c++) vec[c] = 16'd50;
    vec[1] = 16'h7FFF;
    send_vec(3, -1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy",  32'(o_busy),  32'd0);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_max",   32'(o_max),   32'd0);
    chk("mrst_ready", 32'(o_ready), 32'd1);
    rst_n = 1'b1;
    vec[0] = 16'd100;
    for (int c = 1; c < 10; c++) vec[c] = 16'($urandom_range(0, 99));
    send_vec(5, -1, 0);
    check_result("fresh");
    chk("fresh_lit_class", 32'(o_class), 32'd0);
    chk("fresh_lit_max",   32'(o_max),   32'd100);
    drain(0, "fresh");

    for (int r = 0; r < 24; r++) begin
      int mode, gap_at, gap_len, hold;
      mode    = int'($urandom_range(0, 2));
      gap_at  = int'($urandom_range(0, 4)) - 1;
      gap_len = int'($urandom_range(1, 3));
      hold    = int'($urandom_range(0, 3));
      for (int c = 0; c < 10; c++) begin
        vec[c] = (mode == 0) ? 16'($urandom) :
                 (mode == 1) ? pool[$urandom_range(0, 4)] : 16'($urandom_range(0, 3));
      end
      send_vec(5, gap_at, gap_len);
      check_result("rnd");
      drain(hold, "rnd");
    end

    // Single-lane instance: all-equal vector, then random ones.
    for (int c = 0; c < 10; c++) lvec[c] = 16'd0;
    for (int c = 0; c < 4; c++) lvec[c] = 16'd5;
    l_run("l1_eq");
    chk("l1_eq_lit", 32'(l_o_max), 32'd5);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) lvec[c] = pool[$urandom_range(0, 4)];
      l_run("l1_rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
